// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side signals of the two-requester ALU arbiter.
// The arbiter uses the slave modport. The requesters and the ALU use the master modport.
interface alu_arbiter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    // Requester 0 (pipeline EX)
    logic              REQ0_VALID;
    logic [OP_W-1:0]   REQ0_ALUC;
    logic [DATA_W-1:0] REQ0_A;
    logic [DATA_W-1:0] REQ0_B;
    logic              REQ0_READY;

    // Requester 1 (auxiliary unit)
    logic              REQ1_VALID;
    logic [OP_W-1:0]   REQ1_ALUC;
    logic [DATA_W-1:0] REQ1_A;
    logic [DATA_W-1:0] REQ1_B;
    logic              REQ1_READY;

    // Response path, with the result shared by both requesters
    logic              RSP0_VALID;
    logic              RSP1_VALID;
    logic              RSP0_READY;
    logic              RSP1_READY;
    logic [DATA_W-1:0] RSP_RESULT;

    // Shared ALU
    logic [OP_W-1:0]   ALU_C;
    logic [DATA_W-1:0] ALU_A;
    logic [DATA_W-1:0] ALU_B;
    logic [DATA_W-1:0] ALU_R;

    // Status
    logic              GRANT_ID;
    logic              BUSY;

    modport slave (
        input  REQ0_VALID, REQ0_ALUC, REQ0_A, REQ0_B,
        input  REQ1_VALID, REQ1_ALUC, REQ1_A, REQ1_B,
        input  RSP0_READY, RSP1_READY, ALU_R,
        output REQ0_READY, REQ1_READY,
        output RSP0_VALID, RSP1_VALID, RSP_RESULT,
        output ALU_C, ALU_A, ALU_B,
        output GRANT_ID, BUSY
    );

    modport master (
        output REQ0_VALID, REQ0_ALUC, REQ0_A, REQ0_B,
        output REQ1_VALID, REQ1_ALUC, REQ1_A, REQ1_B,
        output RSP0_READY, RSP1_READY, ALU_R,
        input  REQ0_READY, REQ1_READY,
        input  RSP0_VALID, RSP1_VALID, RSP_RESULT,
        input  ALU_C, ALU_A, ALU_B,
        input  GRANT_ID, BUSY
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// The FSM runs IDLE -> EXEC -> RESP with a fixed two-cycle accept-to-response latency.
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration with a 1-bit pointer.
// When the macro is not defined, requester 0 has fixed priority.
// REQn_READY is a combinational decode of IDLE and the winner, so that an accept happens
// in the same cycle. All other outputs come from registers.
module alu_arbiter (
    input  logic         clock,
    input  logic         resetn,
    alu_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   alu_c_q, alu_c_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              grant_q, grant_d;
    logic              rsp0_valid_q, rsp1_valid_q;
    logic              busy_q;

    logic              any_req_c;
    logic              win_c;
    logic              accept_c;

    assign any_req_c = bus.REQ0_VALID | bus.REQ1_VALID;

`ifdef ALU_ARB_RR_EN
    // The pointer names the requester that wins a tie. It always points away from the last grant.
    logic ptr_q, ptr_d;

    // Winner: a lone requester always wins, and the pointer settles a tie
    always_comb begin
        win_c = 1'b0;
        if (bus.REQ0_VALID && bus.REQ1_VALID) begin
            win_c = ptr_q;
        end else begin
            win_c = bus.REQ1_VALID;
        end
    end

    assign ptr_d = accept_c ? ~win_c : ptr_q;

    // Round-robin pointer: after reset it favours requester 0, and it moves only on an accept
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Winner: requester 0 whenever it is valid
    assign win_c = ~bus.REQ0_VALID;
`endif

    // Next state: latch the winner's operation, capture the ALU result, then wait for the response handshake
    always_comb begin
        state_d  = state_q;
        alu_c_d  = alu_c_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;
        grant_d  = grant_q;
        accept_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    accept_c = 1'b1;
                    grant_d  = win_c;
                    alu_c_d  = win_c ? bus.REQ1_ALUC : bus.REQ0_ALUC;
                    alu_a_d  = win_c ? bus.REQ1_A    : bus.REQ0_A;
                    alu_b_d  = win_c ? bus.REQ1_B    : bus.REQ0_B;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = bus.ALU_R;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (grant_q ? bus.RSP1_READY : bus.RSP0_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers: reset discards any in-flight operation
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            alu_c_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            result_q     <= '0;
            grant_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_c_q      <= alu_c_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            result_q     <= result_d;
            grant_q      <= grant_d;
            rsp0_valid_q <= (state_d == S_RESP) && !grant_d;
            rsp1_valid_q <= (state_d == S_RESP) &&  grant_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign bus.REQ0_READY = accept_c & ~win_c;
    assign bus.REQ1_READY = accept_c &  win_c;
    assign bus.RSP0_VALID = rsp0_valid_q;
    assign bus.RSP1_VALID = rsp1_valid_q;
    assign bus.RSP_RESULT = result_q;
    assign bus.ALU_C      = alu_c_q;
    assign bus.ALU_A      = alu_a_q;
    assign bus.ALU_B      = alu_b_q;
    assign bus.GRANT_ID   = grant_q;
    assign bus.BUSY       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// It combines a vector table, directed corner-case sequences and a randomized
// run that is checked against a transaction-level reference model.
// The bench stands in for the shared ALU with a small combinational function.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    // Stand-in ALU: the opcodes used by the bench. Any other opcode gives A^B.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a ^ b;
            4'b1111: return {b[15:0], 16'h0000};
            default: return a ^ b;
        endcase
    endfunction

    assign bus.ALU_R = alu_f(bus.ALU_C, bus.ALU_A, bus.ALU_B);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.REQ0_VALID = 1'b0; bus.REQ0_ALUC = 4'h0; bus.REQ0_A = 32'h0; bus.REQ0_B = 32'h0;
        bus.REQ1_VALID = 1'b0; bus.REQ1_ALUC = 4'h0; bus.REQ1_A = 32'h0; bus.REQ1_B = 32'h0;
        bus.RSP0_READY = 1'b0; bus.RSP1_READY = 1'b0;
    endtask

    task automatic set_req(input bit id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            bus.REQ1_VALID = 1'b1; bus.REQ1_ALUC = c; bus.REQ1_A = a; bus.REQ1_B = b;
        end else begin
            bus.REQ0_VALID = 1'b1; bus.REQ0_ALUC = c; bus.REQ0_A = a; bus.REQ0_B = b;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_c"},  32'(bus.ALU_C), 0);
        check({tag, "_alu_a"},  bus.ALU_A, 0);
        check({tag, "_alu_b"},  bus.ALU_B, 0);
        check({tag, "_result"}, bus.RSP_RESULT, 0);
        check({tag, "_grant"},  32'(bus.GRANT_ID), 0);
        check({tag, "_rsp0v"},  32'(bus.RSP0_VALID), 0);
        check({tag, "_rsp1v"},  32'(bus.RSP1_VALID), 0);
        check({tag, "_busy"},   32'(bus.BUSY), 0);
    endtask

    // Assert reset for two edges, then release it just after a rising edge
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check_zero("rst");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One complete transaction on an otherwise quiet bus, with its cycle-by-cycle checks
    task automatic run_op(input bit id, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r);
        set_req(id, c, a, b);
        mid();
        check("op_ready", 32'(id ? bus.REQ1_READY : bus.REQ0_READY), 1);
        check("op_ready_other", 32'(id ? bus.REQ0_READY : bus.REQ1_READY), 0);
        check("op_busy_idle", 32'(bus.BUSY), 0);
        tick();
        clear_inputs();
        mid();
        check("op_alu_c", 32'(bus.ALU_C), 32'(c));
        check("op_alu_a", bus.ALU_A, a);
        check("op_alu_b", bus.ALU_B, b);
        check("op_grant", 32'(bus.GRANT_ID), 32'(id));
        check("op_busy_exec", 32'(bus.BUSY), 1);
        check("op_rsp_early", 32'(bus.RSP0_VALID | bus.RSP1_VALID), 0);
        tick();
        mid();
        check("op_rsp_valid", 32'(id ? bus.RSP1_VALID : bus.RSP0_VALID), 1);
        check("op_rsp_other", 32'(id ? bus.RSP0_VALID : bus.RSP1_VALID), 0);
        check("op_result", bus.RSP_RESULT, exp_r);
        check("op_alu_c_stable", 32'(bus.ALU_C), 32'(c));
        if (id) bus.RSP1_READY = 1'b1; else bus.RSP0_READY = 1'b1;
        tick();
        clear_inputs();
        mid();
        check("op_busy_done", 32'(bus.BUSY), 0);
        check("op_rsp_done", 32'(bus.RSP0_VALID | bus.RSP1_VALID), 0);
        check("op_result_hold", bus.RSP_RESULT, exp_r);
        check("op_grant_hold", 32'(bus.GRANT_ID), 32'(id));
        tick();
    endtask

    typedef struct {
        bit          id;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    initial begin
        vec_t        tbl [8];
        logic [31:0] gr [3];
        logic [31:0] rr [3];
        logic [31:0] exp_g [3];
        logic [31:0] exp_r [3];
        int          ng;
        int          nr;
        // Reference model state, kept at transaction level
        bit          m_out;
        bit          m_id;
        int          m_age;
        bit          m_last;
        bit          m_gid;
        logic [3:0]  m_c;
        logic [31:0] m_a, m_b, m_res;
        bit          pend [2];
        logic [3:0]  rc [2];
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        bit          rr0, rr1, any, win;

        tbl[0] = '{1'b0, 4'b0010, 32'd5,         32'd7,         32'd12};
        tbl[1] = '{1'b1, 4'b0110, 32'd9,         32'd4,         32'd5};
        tbl[2] = '{1'b0, 4'b0001, 32'h000000F0,  32'h0000000F,  32'h000000FF};
        tbl[3] = '{1'b1, 4'b1111, 32'hDEADBEEF,  32'h00001234,  32'h12340000};
        tbl[4] = '{1'b1, 4'b1011, 32'd3,         32'd5,         32'd6};
        tbl[5] = '{1'b0, 4'b0000, 32'hFF00FF00,  32'h0F0F0F0F,  32'h0F000F00};
        tbl[6] = '{1'b0, 4'b0110, 32'd0,         32'd1,         32'hFFFFFFFF};
        tbl[7] = '{1'b1, 4'b0010, 32'hFFFFFFFF,  32'd1,         32'd0};

        rst_n = 1'b0;
        do_reset();
        // The first table entry is applied in the first cycle after reset is released
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].id, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].r);
        end

        // Tie: both requesters stay valid for three back-to-back operations
        do_reset();
        set_req(1'b0, 4'b0110, 32'd9, 32'd4);
        set_req(1'b1, 4'b0001, 32'h000000F0, 32'h0000000F);
        bus.RSP0_READY = 1'b1;
        bus.RSP1_READY = 1'b1;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            mid();
            check("tie_ready_excl", 32'(bus.REQ0_READY & bus.REQ1_READY), 0);
            if (bus.REQ0_READY || bus.REQ1_READY) begin
                if (ng < 3) gr[ng] = 32'(bus.REQ1_READY);
                ng++;
            end
            if (bus.RSP0_VALID || bus.RSP1_VALID) begin
                if (nr < 3) rr[nr] = bus.RSP_RESULT;
                nr++;
            end
            tick();
        end
        clear_inputs();
`ifdef ALU_ARB_RR_EN
        exp_g = '{32'd0, 32'd1, 32'd0};
        exp_r = '{32'd5, 32'hFF, 32'd5};
`else
        exp_g = '{32'd0, 32'd0, 32'd0};
        exp_r = '{32'd5, 32'd5, 32'd5};
`endif
        check("tie_grant_count", 32'(ng), 3);
        check("tie_result_count", 32'(nr), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < ng) check("tie_grant", gr[i], exp_g[i]);
            if (i < nr) check("tie_result", rr[i], exp_r[i]);
        end
        tick();

        // Backpressure: requester 1 holds off its response while requester 0 waits
        set_req(1'b1, 4'b0010, 32'd100, 32'd23);
        mid();
        check("bp_ready1", 32'(bus.REQ1_READY), 1);
        tick();
        clear_inputs();
        tick();
        set_req(1'b0, 4'b0010, 32'd1, 32'd2);
        for (int k = 0; k < 4; k++) begin
            mid();
            check("bp_rsp1_valid", 32'(bus.RSP1_VALID), 1);
            check("bp_result", bus.RSP_RESULT, 32'd123);
            check("bp_alu_c", 32'(bus.ALU_C), 32'h2);
            check("bp_alu_a", bus.ALU_A, 32'd100);
            check("bp_alu_b", bus.ALU_B, 32'd23);
            check("bp_ready0", 32'(bus.REQ0_READY), 0);
            tick();
        end
        bus.RSP1_READY = 1'b1;
        mid();
        check("bp_rsp1_last", 32'(bus.RSP1_VALID), 1);
        check("bp_ready0_last", 32'(bus.REQ0_READY), 0);
        tick();
        bus.RSP1_READY = 1'b0;
        mid();
        check("bp_ready0_after", 32'(bus.REQ0_READY), 1);
        tick();
        clear_inputs();
        mid();
        check("bp_alu_a_next", bus.ALU_A, 32'd1);
        tick();
        mid();
        check("bp_rsp0_valid", 32'(bus.RSP0_VALID), 1);
        check("bp_result_next", bus.RSP_RESULT, 32'd3);
        bus.RSP0_READY = 1'b1;
        tick();
        clear_inputs();
        tick();

        // Reset during EXEC discards the operation
        set_req(1'b0, 4'b0010, 32'd40, 32'd2);
        mid();
        tick();
        clear_inputs();
        mid();
        check("rx_busy_exec", 32'(bus.BUSY), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("rx");
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            check("rx_no_rsp", 32'(bus.RSP0_VALID | bus.RSP1_VALID), 0);
            check("rx_idle", 32'(bus.BUSY), 0);
            tick();
        end

        // Stray RSP0_READY, first in IDLE and then while requester 1 owns the response
        bus.RSP0_READY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid();
            check("stray_idle_busy", 32'(bus.BUSY), 0);
            check("stray_idle_rsp", 32'(bus.RSP0_VALID | bus.RSP1_VALID), 0);
            tick();
        end
        set_req(1'b1, 4'b1111, 32'd0, 32'h00001234);
        mid();
        check("stray_ready1", 32'(bus.REQ1_READY), 1);
        tick();
        clear_inputs();
        bus.RSP0_READY = 1'b1;
        mid();
        check("stray_alu_c", 32'(bus.ALU_C), 32'hF);
        tick();
        for (int k = 0; k < 3; k++) begin
            mid();
            check("stray_rsp1_valid", 32'(bus.RSP1_VALID), 1);
            check("stray_rsp0_valid", 32'(bus.RSP0_VALID), 0);
            check("stray_grant", 32'(bus.GRANT_ID), 1);
            check("stray_result", bus.RSP_RESULT, 32'h12340000);
            tick();
        end
        bus.RSP1_READY = 1'b1;
        tick();
        clear_inputs();
        mid();
        check("stray_done_busy", 32'(bus.BUSY), 0);
        check("stray_result_hold", bus.RSP_RESULT, 32'h12340000);
        tick();

        // Randomized traffic checked against the transaction-level model
        do_reset();
        m_out = 1'b0; m_id = 1'b0; m_age = 0; m_last = 1'b1; m_gid = 1'b0;
        m_c = 4'h0; m_a = 32'h0; m_b = 32'h0; m_res = 32'h0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    rc[r] = 4'($urandom_range(0, 15));
                    ra[r] = $urandom;
                    rb[r] = $urandom;
                end
            end
            bus.REQ0_VALID = pend[0]; bus.REQ0_ALUC = rc[0]; bus.REQ0_A = ra[0]; bus.REQ0_B = rb[0];
            bus.REQ1_VALID = pend[1]; bus.REQ1_ALUC = rc[1]; bus.REQ1_A = ra[1]; bus.REQ1_B = rb[1];
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            bus.RSP0_READY = rr0;
            bus.RSP1_READY = rr1;
            mid();
            any = pend[0] | pend[1];
`ifdef ALU_ARB_RR_EN
            win = (pend[0] && pend[1]) ? !m_last : pend[1];
`else
            win = (pend[0] && pend[1]) ? 1'b0 : pend[1];
`endif
            check("rnd_ready0", 32'(bus.REQ0_READY), 32'(!m_out && any && !win));
            check("rnd_ready1", 32'(bus.REQ1_READY), 32'(!m_out && any && win));
            check("rnd_busy", 32'(bus.BUSY), 32'(m_out));
            check("rnd_rsp0", 32'(bus.RSP0_VALID), 32'(m_out && m_age >= 2 && !m_id));
            check("rnd_rsp1", 32'(bus.RSP1_VALID), 32'(m_out && m_age >= 2 && m_id));
            check("rnd_result", bus.RSP_RESULT, m_res);
            check("rnd_grant", 32'(bus.GRANT_ID), 32'(m_gid));
            check("rnd_alu_c", 32'(bus.ALU_C), 32'(m_c));
            check("rnd_alu_a", bus.ALU_A, m_a);
            check("rnd_alu_b", bus.ALU_B, m_b);
            if (m_out) begin
                if (m_age >= 2 && (m_id ? rr1 : rr0)) begin
                    m_out = 1'b0;
                end else if (m_age < 2) begin
                    m_age++;
                    m_res = alu_f(m_c, m_a, m_b);
                end
            end else if (any) begin
                m_out = 1'b1; m_age = 1; m_id = win; m_gid = win; m_last = win;
                m_c = rc[win]; m_a = ra[win]; m_b = rb[win];
            end
            if (bus.REQ0_READY) pend[0] = 1'b0;
            if (bus.REQ1_READY) pend[1] = 1'b0;
            tick();
        end
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have the following ports, one per line as name, direction, width and meaning, with clock and reset first.
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- REQ0_VALID  in  1  requester 0 (pipeline EX) has an operation
- REQ0_ALUC  in  4  requester 0 ALU opcode
- REQ0_A, REQ0_B  in  32 each  requester 0 operands
- REQ0_READY  out  1  requester 0 operation accepted this cycle
- REQ1_VALID, REQ1_ALUC, REQ1_A, REQ1_B, REQ1_READY  same as requester 0, for requester 1 (auxiliary unit)
- RSP0_VALID, RSP1_VALID  out  1 each  result valid for requester n
- RSP0_READY, RSP1_READY  in  1 each  requester n takes its result
- RSP_RESULT  out  32  result, shared by both requesters
- ALU_C  out  4  registered opcode to the shared ALU's EALUC input
- ALU_A, ALU_B  out  32 each  registered operands to the ALU's EXA and EXB inputs
- ALU_R  in  32  combinational ALU result (EXALU)
- GRANT_ID  out  1  requester that owns the current operation
- BUSY  out  1  high whenever state is not IDLE

Function
REQ-002 The module SHALL implement a three-state FSM with states IDLE, EXEC and RESP.
REQ-003 In IDLE with at least one REQn_VALID high, the module SHALL pick a winner, assert that requester's REQn_READY combinationally in the same cycle, and set GRANT_ID to the winner.
REQ-004 On that clock edge, the module SHALL latch the winner's ALUC, A and B into ALU_C, ALU_A and ALU_B, and SHALL move to EXEC.
REQ-005 REQn_READY SHALL be low in EXEC and RESP, and in IDLE for the losing requester.
REQ-006 In EXEC, the module SHALL capture ALU_R into RSP_RESULT at the end of the cycle and SHALL move to RESP; the ALU outputs SHALL stay stable through EXEC and RESP.
REQ-007 In RESP, RSPn_VALID SHALL be high only for n equal to GRANT_ID.
REQ-008 In RESP, the module SHALL stay in RESP until RSPn_READY is high, then return to IDLE on that edge.
REQ-009 RSP_RESULT and GRANT_ID SHALL hold their values through IDLE until the next accept.
REQ-010 Latency SHALL be fixed: an accept in cycle T SHALL give RSPn_VALID high in cycle T+2 at the earliest.
REQ-011 There SHALL be no bypass from RESP to a new accept, so peak throughput is one operation per 3 cycles.
REQ-012 A requester SHALL hold VALID and its operands stable until it sees READY; the module SHALL NOT check this rule.
REQ-013 The module SHALL pass REQn_ALUC through unchanged, and SHALL forward undefined opcodes without any error signalling.
REQ-014 An RSPn_READY that arrives while RSPn_VALID is low SHALL be ignored.
REQ-015 An RSPn_READY for the non-granted requester SHALL be ignored.

Reset
REQ-016 When resetn is low, the FSM SHALL go to IDLE asynchronously.
REQ-017 When resetn is low, these outputs SHALL be 0: ALU_C, ALU_A, ALU_B, RSP_RESULT, GRANT_ID, RSPn_VALID and BUSY; the round-robin pointer SHALL favour requester 0.
REQ-018 A reset during EXEC or RESP SHALL discard the in-flight operation, and no response SHALL be produced for it after reset is released.
REQ-019 The first accept SHALL be possible in the first clock cycle in which resetn is high.

Configuration
REQ-020 When ALU_ARB_RR_EN is defined, arbitration SHALL be round-robin using a 1-bit pointer.
REQ-021 With round-robin, if both requesters are valid in IDLE, the requester not granted last SHALL win.
REQ-022 With round-robin, the pointer SHALL update only on an accept.
REQ-023 With round-robin, a lone valid requester SHALL always win, regardless of the pointer.
REQ-024 When ALU_ARB_RR_EN is not defined, arbitration SHALL be fixed priority with requester 0 always winning a tie, and no pointer register SHALL exist.

Verification
REQ-025 Single op: REQ0 (ALUC=0010, A=5, B=7) in the first cycle after reset -> REQ0_READY high in the same cycle; ALU_C=0010, ALU_A=5, ALU_B=7 in the next cycle; RSP0_VALID high with RSP_RESULT=12 two cycles after the accept.
REQ-026 Tie under round-robin: both requesters valid back-to-back, with REQ0 doing SUB 9,4 and REQ1 doing OR 0xF0,0x0F -> grants go 0,1,0 and results are 5, 0xFF, 5; without the macro -> grants go 0,0,0.
REQ-027 Backpressure: RSP1_READY held low for 4 cycles in RESP -> RSP1_VALID, RSP_RESULT and ALU operands all stable, and REQ0_READY stays low even with REQ0_VALID high.
REQ-028 Reset mid-EXEC: resetn pulsed low during EXEC -> all outputs 0 immediately, and no RSPn_VALID appears afterwards.
REQ-029 Stray ready: RSP0_READY high in IDLE and while GRANT_ID=1 -> no state change, and RSP1_VALID stays high until RSP1_READY.
REQ-030 Opcode passthrough: REQ1_ALUC=1111 with B=0x00001234 -> RSP_RESULT=0x12340000; REQ1_ALUC=1011 -> forwarded unchanged on ALU_C and a response still returned.
